power_seq_unit: RTL and testbench



---
 rtl/power_seq_pkg.sv | 32 +++
 rtl/power_seq_ls_tick_gen.sv | 34 +++
 rtl/power_seq_unit.sv | 204 ++++++++++++++++++++
 tb/tb_power_seq_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_seq_pkg.sv
// Shared definitions for the core sleep / memory power sequencer:
// state codes, register map and register bit positions.
package power_seq_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SHUTDOWN  = 3'd1,
        ST_SLEEP     = 3'd2,
        ST_EXT_SLEEP = 3'd3,
        ST_WAKEUP    = 3'd4
    } pseq_state_e;

    localparam int unsigned REG_CTRL       = 32'h0;
    localparam int unsigned REG_STATUS     = 32'h4;
    localparam int unsigned REG_BANK_MASK  = 32'h8;
    localparam int unsigned REG_WAKE_DELAY = 32'hC;

    localparam int CTRL_SLEEP_EN     = 0;
    localparam int CTRL_EXT_EN       = 1;
    localparam int STAT_SLEEPING     = 0;
    localparam int STAT_EXT_SLEEPING = 1;
    localparam int STAT_STATE_LSB    = 4;

    function automatic logic is_ext(pseq_state_e s);
        return (s == ST_EXT_SLEEP) || (s == ST_WAKEUP);
    endfunction

    function automatic logic is_sleeping(pseq_state_e s);
        return (s == ST_SLEEP) || is_ext(s);
    endfunction

endpackage

// File: rtl/power_seq_ls_tick_gen.sv
// Low-speed tick: clk32_i rising edge brought into HCLK through a 2-flop
// synchroniser and a registered edge detect; clk32_en_i=0 ticks every cycle.
module ls_tick_gen (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clk32_i,
    input  logic clk32_en_i,
    output logic tick_o
);

    logic sync1_q, sync2_q, prev_q, edge_q;
    logic edge_d;

    always_comb begin
        edge_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= clk32_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= edge_d;
        end
    end

    assign tick_o = ~clk32_en_i | edge_q;

endmodule

// File: rtl/power_seq_unit.sv
// APB-controlled core sleep and memory bank power sequencer. Extended sleep
// power-gates a latched bank subset; wake-up releases banks one per step.
module power_seq_unit
    import power_seq_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_BANKS        = 4,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic                      clk32_i,
    input  logic                      clk32_en_i,
    input  logic                      irq_i,
    input  logic                      event_i,
    input  logic                      core_busy_i,
    output logic                      fetch_en_o,
    output logic                      clk_gate_core_o,
    output logic                      mem_sleep_o,
    output logic [N_BANKS-1:0]        mem_gate_o
);

    localparam int IDX_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BANKS - 1);

    pseq_state_e          state_q, state_d;
    logic                 sleep_en_q, sleep_en_d;
    logic                 ext_en_q, ext_en_d;
    logic [N_BANKS-1:0]   bank_mask_q, bank_mask_d;
    logic [CNT_WIDTH-1:0] wake_delay_q, wake_delay_d;
    logic [N_BANKS-1:0]   mask_q, mask_d;
    logic [CNT_WIDTH-1:0] dly_q, dly_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 tick;
    logic                 step_done;

    ls_tick_gen u_tick (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .clk32_i    (clk32_i),
        .clk32_en_i (clk32_en_i),
        .tick_o     (tick)
    );

    // APB decode: zero wait states, error on unmapped offsets or STATUS writes
    logic access, wr_en, rd_en, mapped;
    logic sel_ctrl, sel_stat, sel_mask, sel_dly;
    logic [31:0] prdata;
    logic unused_pwdata;

    assign access   = PSEL & PENABLE;
    assign wr_en    = access & PWRITE;
    assign rd_en    = access & ~PWRITE;
    assign sel_ctrl = (PADDR == APB_ADDR_WIDTH'(REG_CTRL));
    assign sel_stat = (PADDR == APB_ADDR_WIDTH'(REG_STATUS));
    assign sel_mask = (PADDR == APB_ADDR_WIDTH'(REG_BANK_MASK));
    assign sel_dly  = (PADDR == APB_ADDR_WIDTH'(REG_WAKE_DELAY));
    assign mapped   = sel_ctrl | sel_stat | sel_mask | sel_dly;
    assign PREADY   = 1'b1;
    assign PSLVERR  = access & (~mapped | (PWRITE & sel_stat));
    assign unused_pwdata = ^PWDATA;

    always_comb begin
        prdata = '0;
        if (rd_en) begin
            if (sel_ctrl) begin
                prdata[CTRL_SLEEP_EN] = sleep_en_q;
                prdata[CTRL_EXT_EN]   = ext_en_q;
            end
            if (sel_stat) begin
                prdata[STAT_SLEEPING]           = is_sleeping(state_q);
                prdata[STAT_EXT_SLEEPING]       = is_ext(state_q);
                prdata[STAT_STATE_LSB +: 3]     = state_q;
            end
            if (sel_mask) prdata[N_BANKS-1:0]   = bank_mask_q;
            if (sel_dly)  prdata[CNT_WIDTH-1:0] = wake_delay_q;
        end
    end

    assign PRDATA = prdata;

    // Hardware clears first so a same-cycle software write wins
    always_comb begin
        sleep_en_d   = sleep_en_q;
        ext_en_d     = ext_en_q;
        bank_mask_d  = bank_mask_q;
        wake_delay_d = wake_delay_q;
        if ((state_q == ST_SLEEP) || event_i) sleep_en_d = 1'b0;
        if (is_ext(state_q) || event_i)      ext_en_d   = 1'b0;
        if (wr_en && sel_ctrl) begin
            sleep_en_d = PWDATA[CTRL_SLEEP_EN];
            ext_en_d   = PWDATA[CTRL_EXT_EN];
        end
        if (wr_en && sel_mask) bank_mask_d  = PWDATA[N_BANKS-1:0];
        if (wr_en && sel_dly)  wake_delay_d = PWDATA[CNT_WIDTH-1:0];
    end

    // A gated step ends on the tick that finds cnt already at the delay
    assign step_done = ~mask_q[idx_q] | (tick & (cnt_q == dly_q));

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dly_d   = dly_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (sleep_en_q && !event_i) state_d = ST_SHUTDOWN;
            end
            ST_SHUTDOWN: begin
                if (event_i)                   state_d = ST_RUN;
                else if (!core_busy_i && !irq_i) state_d = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (event_i)     state_d = ST_RUN;
                else if (irq_i)  state_d = ST_SHUTDOWN;
                else if (ext_en_q) begin
                    state_d = ST_EXT_SLEEP;
                    mask_d  = bank_mask_q;
                    dly_d   = wake_delay_q;
                end
            end
            ST_EXT_SLEEP: begin
                if (event_i) begin
                    state_d = ST_WAKEUP;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_WAKEUP: begin
                if (step_done) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (tick && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        fetch_en_o      = 1'b0;
        clk_gate_core_o = 1'b1;
        mem_sleep_o     = 1'b0;
        mem_gate_o      = '0;
        case (state_q)
            ST_RUN:       fetch_en_o = ~(sleep_en_q & ~event_i);
            ST_SLEEP:     clk_gate_core_o = event_i;
            ST_EXT_SLEEP: begin
                clk_gate_core_o = 1'b0;
                mem_sleep_o     = 1'b1;
                mem_gate_o      = mask_q;
            end
            ST_WAKEUP: begin
                clk_gate_core_o = 1'b0;
                mem_sleep_o     = 1'b1;
                for (int i = 0; i < N_BANKS; i++)
                    mem_gate_o[i] = mask_q[i] & (IDX_W'(i) > idx_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_RUN;
            sleep_en_q   <= 1'b0;
            ext_en_q     <= 1'b0;
            bank_mask_q  <= '0;
            wake_delay_q <= '0;
            mask_q       <= '0;
            dly_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            sleep_en_q   <= sleep_en_d;
            ext_en_q     <= ext_en_d;
            bank_mask_q  <= bank_mask_d;
            wake_delay_q <= wake_delay_d;
            mask_q       <= mask_d;
            dly_q        <= dly_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
        end
    end

endmodule

// File: tb/tb_power_seq_unit.sv
// Bench for power_seq_unit: directed scenarios plus randomized traffic against
// a step-countdown reference model of the sleep and wake-up rules.
module tb_power_seq_unit;

    localparam int AW = 12;
    localparam int NB = 4;
    localparam int CW = 8;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [AW-1:0] PADDR = '0;
    logic [31:0]   PWDATA = '0;
    logic          PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;
    logic          clk32_i = 1'b0, clk32_en_i = 1'b0;
    logic          irq_i = 1'b0, event_i = 1'b0, core_busy_i = 1'b0;
    logic          fetch_en_o, clk_gate_core_o, mem_sleep_o;
    logic [NB-1:0] mem_gate_o;

    power_seq_unit #(.APB_ADDR_WIDTH(AW), .N_BANKS(NB), .CNT_WIDTH(CW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .clk32_i(clk32_i), .clk32_en_i(clk32_en_i),
        .irq_i(irq_i), .event_i(event_i), .core_busy_i(core_busy_i),
        .fetch_en_o(fetch_en_o), .clk_gate_core_o(clk_gate_core_o),
        .mem_sleep_o(mem_sleep_o), .mem_gate_o(mem_gate_o)
    );

    always #5  HCLK    = ~HCLK;
    always #40 clk32_i = ~clk32_i;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state codes 0..4 as listed for STATUS; a wake step is
    // tracked as a countdown of remaining cycles (ticks every cycle here).
    int m_state, m_mask, m_dly, m_lmask, m_ldly, m_idx, m_left;
    bit m_sen, m_een;
    bit model_on = 1'b1;

    logic [31:0]   rd_q;
    logic          slverr_q, cg_q, ms_q;
    logic [NB-1:0] gate_q;

    function automatic int step_len(int i);
        return ((m_lmask >> i) & 1) ? (m_ldly + 1) : 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_mask = 0; m_dly = 0; m_lmask = 0; m_ldly = 0;
        m_idx = 0; m_left = 0; m_sen = 0; m_een = 0;
    endtask

    task automatic cyc();
        bit ev, irq, busy, acc, wr, mapped, n_sen, n_een;
        int addr, wd, ns, e_fetch, e_cg, e_ms, e_gate;
        @(negedge HCLK);
        ev = event_i; irq = irq_i; busy = core_busy_i;
        acc = PSEL && PENABLE; wr = PWRITE; addr = int'(PADDR); wd = PWDATA;
        rd_q = PRDATA; slverr_q = PSLVERR; gate_q = mem_gate_o;
        cg_q = clk_gate_core_o; ms_q = mem_sleep_o;
        if (model_on) begin
            e_fetch = 0; e_cg = 1; e_ms = 0; e_gate = 0;
            case (m_state)
                0: e_fetch = !(m_sen && !ev);
                2: e_cg = ev;
                3: begin e_cg = 0; e_ms = 1; e_gate = m_lmask; end
                4: begin e_cg = 0; e_ms = 1; e_gate = m_lmask & ~((1 << (m_idx + 1)) - 1); end
                default: ;
            endcase
            chk("fetch_en", fetch_en_o, e_fetch);
            chk("clk_gate", clk_gate_core_o, e_cg);
            chk("mem_sleep", mem_sleep_o, e_ms);
            chk("mem_gate", 32'(mem_gate_o), e_gate & ((1 << NB) - 1));
            chk("pready", PREADY, 1);
            if (acc) begin
                mapped = (addr == 0) || (addr == 4) || (addr == 8) || (addr == 12);
                chk("pslverr", PSLVERR, !mapped || (wr && addr == 4));
                if (!wr) begin
                    case (addr)
                        0:  chk("rd_ctrl", PRDATA, {m_een, m_sen});
                        4: begin
                            chk("rd_state", PRDATA & 32'h70, m_state << 4);
                            if (m_state == 0 || m_state == 2)
                                chk("rd_sleeping", PRDATA & 32'h1, m_state == 2);
                        end
                        8:  chk("rd_mask", PRDATA, m_mask);
                        12: chk("rd_delay", PRDATA, m_dly);
                        default: chk("rd_unmapped", PRDATA, 0);
                    endcase
                end
            end
            ns = m_state;
            case (m_state)
                0: if (m_sen && !ev) ns = 1;
                1: if (ev) ns = 0; else if (!busy && !irq) ns = 2;
                2: if (ev) ns = 0;
                   else if (irq) ns = 1;
                   else if (m_een) begin ns = 3; m_lmask = m_mask; m_ldly = m_dly; end
                3: if (ev) begin ns = 4; m_idx = 0; m_left = step_len(0); end
                4: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_idx == NB - 1) ns = 0;
                        else begin m_idx++; m_left = step_len(m_idx); end
                    end
                end
                default: ;
            endcase
            n_sen = (m_state == 2 || ev) ? 1'b0 : m_sen;
            n_een = (m_state == 3 || m_state == 4 || ev) ? 1'b0 : m_een;
            if (acc && wr && addr == 0) begin n_sen = wd[0]; n_een = wd[1]; end
            if (acc && wr && addr == 8)  m_mask = wd & ((1 << NB) - 1);
            if (acc && wr && addr == 12) m_dly  = wd & 255;
            m_sen = n_sen; m_een = n_een; m_state = ns;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic apb_wr(input int a, input int d);
        PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = AW'(a); PWDATA = d;
        cyc();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_rd(input int a);
        PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = AW'(a);
        cyc();
        PSEL = 0; PENABLE = 0;
    endtask

    logic [3:0] exp_seq [12] = '{4'hB, 4'hA, 4'hA, 4'hA, 4'h8, 4'h8, 4'h8, 4'h8,
                                 4'h0, 4'h0, 4'h0, 4'h0};

    initial begin
        int t, t1, t2, t3, d1, d2, a, sel, wd;
        model_reset();
        #12;
        chk("rst_fetch", fetch_en_o, 1);
        chk("rst_cg", clk_gate_core_o, 1);
        chk("rst_ms", mem_sleep_o, 0);
        chk("rst_gate", 32'(mem_gate_o), 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_pready", PREADY, 1);
        chk("rst_pslverr", PSLVERR, 0);
        @(posedge HCLK); #1;
        HRESETn = 1;
        cyc();

        // Basic sleep and event wake
        apb_wr(12, 2);
        apb_wr(8, 32'hB);
        apb_wr(0, 1);
        cyc(); cyc();
        apb_rd(4);
        chk("sleep_status", rd_q & 32'h71, 32'h21);
        chk("sleep_cg", cg_q, 0);
        event_i = 1; cyc(); event_i = 0;
        apb_rd(0);
        chk("wake_ctrl_clr", rd_q, 0);
        apb_rd(4);
        chk("wake_run", rd_q & 32'h70, 0);

        // irq in SLEEP returns to SHUTDOWN
        apb_wr(0, 1);
        cyc(); cyc();
        irq_i = 1; cyc(); irq_i = 0;
        apb_rd(4);
        chk("irq_shutdown", rd_q & 32'h70, 32'h10);
        event_i = 1; cyc(); event_i = 0;
        cyc();

        // event_i during SLEEP_EN write keeps the unit running
        event_i = 1;
        apb_wr(0, 1);
        cyc();
        event_i = 0;
        apb_rd(4);
        chk("ev_wr_run", rd_q & 32'h70, 0);
        apb_rd(0);
        chk("ev_wr_ctrl", rd_q, 0);

        // Extended sleep, mask 1011, delay 2, mask rewritten mid wake-up
        apb_wr(0, 3);
        cyc(); cyc(); cyc();
        for (int i = 0; i < 12; i++) begin
            if (i == 0) event_i = 1;
            if (i == 2) begin
                PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = AW'(8); PWDATA = 0;
            end
            cyc();
            event_i = 0; PSEL = 0; PENABLE = 0; PWRITE = 0;
            chk($sformatf("wake_seq%0d", i), 32'(gate_q), 32'(exp_seq[i]));
        end
        apb_rd(8);
        chk("mask_readback", rd_q, 0);
        apb_rd(4);
        chk("ext_done_run", rd_q & 32'h70, 0);

        // Slow tick: each gated step spans two ticks of clk32_i (8 HCLK each)
        apb_wr(8, 32'hF);
        apb_wr(12, 1);
        model_on = 0;
        clk32_en_i = 1;
        apb_wr(0, 3);
        for (int k = 0; k < 40 && !(ms_q && gate_q == 4'hF); k++) cyc();
        chk("ext_reached", ms_q, 1);
        event_i = 1; cyc(); event_i = 0;
        t = 0; t1 = -1; t2 = -1; t3 = -1;
        while (t < 300 && t3 < 0) begin
            cyc();
            t++;
            if (t1 < 0 && gate_q == 4'hC) t1 = t;
            if (t2 < 0 && gate_q == 4'h8) t2 = t;
            if (t3 < 0 && gate_q == 4'h0) t3 = t;
        end
        chk("slow_steps_done", t3 >= 0, 1);
        d1 = t2 - t1;
        d2 = t3 - t2;
        chk("slow_step1_len", (d1 >= 15 && d1 <= 17) ? 16 : d1, 16);
        chk("slow_step2_len", (d2 >= 15 && d2 <= 17) ? 16 : d2, 16);
        chk("mid_wake_msleep", ms_q, 1);

        // Asynchronous reset in the middle of wake-up
        HRESETn = 0;
        #1;
        chk("arst_fetch", fetch_en_o, 1);
        chk("arst_cg", clk_gate_core_o, 1);
        chk("arst_ms", mem_sleep_o, 0);
        chk("arst_gate", 32'(mem_gate_o), 0);
        chk("arst_prdata", PRDATA, 0);
        chk("arst_pslverr", PSLVERR, 0);
        @(posedge HCLK); #1;
        clk32_en_i = 0;
        HRESETn = 1;
        model_reset();
        model_on = 1;
        apb_rd(16);
        chk("unmapped_rd_data", rd_q, 0);
        chk("unmapped_rd_err", slverr_q, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            event_i     = ($urandom_range(0, 19) == 0);
            irq_i       = ($urandom_range(0, 9) == 0);
            core_busy_i = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) begin
                sel = $urandom_range(0, 5);
                a = (sel < 4) ? sel * 4 : ((sel == 4) ? 16 : $urandom_range(0, 4095));
                wd = $urandom;
                if (a == 12 && $urandom_range(0, 7) != 0) wd = wd & 7;
                PSEL = 1; PENABLE = 1; PWRITE = $urandom_range(0, 1);
                PADDR = AW'(a); PWDATA = wd;
            end
            cyc();
            PSEL = 0; PENABLE = 0; PWRITE = 0;
        end
        event_i = 0; irq_i = 0; core_busy_i = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
